// File: rtl/spram_responder.sv
`default_nettype none
// ============================================================================
// Module   : spram_responder (with ram_pkg sizing defaults)
// Brief    : Single-port RAM responder: stores writes, returns registered read
//            data, flags out-of-range accesses. Optional post-reset sweep of
//            the array to INIT_VALUE when SPRAM_INIT_CLEAR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

package ram_pkg;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
endpackage

module spram_responder #(
    parameter int                        ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
    parameter int                        DATA_WIDTH = ram_pkg::DATA_WIDTH,
    parameter int                        DEPTH      = ram_pkg::DEPTH,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  rd_valid,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_ready;
    logic                  r_rd_valid;
    logic                  r_err;

    logic                  w_in_range;
    logic                  w_acc;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // A fully populated address space needs no range compare.
    generate
        if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_map
            assign w_in_range = 1'b1;
        end else begin : g_partial_map
            localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
            assign w_in_range = ({1'b0, addr} < c_DEPTH);
        end
    endgenerate

    // Accesses in the reset cycle are discarded so reset always wins.
    assign w_acc    = cs & r_ready & ~rst;
    assign w_wr_acc = w_acc & we;
    assign w_rd_acc = w_acc & ~we;

`ifdef SPRAM_INIT_CLEAR_EN
    localparam logic [0:0]            c_ST_INIT  = 1'b0;
    localparam logic [0:0]            c_ST_IDLE  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  w_sweep;

    assign w_sweep = ~rst & (r_state == c_ST_INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_INIT;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // The sweep and initiator writes never overlap: ready is low while sweeping.
    always_ff @(posedge clk) begin
        if (w_sweep) begin
            r_mem[r_idx] <= INIT_VALUE;
        end else if (w_wr_acc && w_in_range) begin
            r_mem[addr] <= data_in;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc && w_in_range) begin
            r_mem[addr] <= data_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_dout     <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_err      <= w_acc & ~w_in_range;
            if (w_rd_acc) begin
                r_dout <= w_in_range ? r_mem[addr] : '0;
            end
        end
    end

    assign data_out = oe ? r_dout : '0;
    assign ready    = r_ready;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spram_responder
// Brief    : Randomized + directed bench for spram_responder; two instances
//            (DEPTH 16 and DEPTH 12) checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_spram_responder;

`ifdef SPRAM_INIT_CLEAR_EN
    localparam bit c_SWEEP = 1'b1;
`else
    localparam bit c_SWEEP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      cs;
    logic [1:0]      we;
    logic [1:0]      oe;
    logic [1:0][3:0] addr;
    logic [1:0][7:0] din;
    logic [1:0][7:0] dout;
    logic [1:0]      rdy;
    logic [1:0]      rv;
    logic [1:0]      er;

    always #5 clk = ~clk;

    spram_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16), .INIT_VALUE(8'h00)) u_dut16 (
        .clk(clk), .rst(rst), .cs(cs[0]), .we(we[0]), .oe(oe[0]), .addr(addr[0]),
        .data_in(din[0]), .data_out(dout[0]), .ready(rdy[0]), .rd_valid(rv[0]), .err(er[0])
    );

    spram_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(12), .INIT_VALUE(8'h00)) u_dut12 (
        .clk(clk), .rst(rst), .cs(cs[1]), .we(we[1]), .oe(oe[1]), .addr(addr[1]),
        .data_in(din[1]), .data_out(dout[1]), .ready(rdy[1]), .rd_valid(rv[1]), .err(er[1])
    );

    function automatic int dep(input int d);
        return (d == 0) ? 16 : 12;
    endfunction

    // Behavioural model: contents, known-flags and expected outputs per instance.
    logic [7:0] mm    [2][16];
    bit         kn    [2][16];
    int         rel   [2];
    logic [7:0] ereg  [2];
    bit         eregk [2];
    bit         erv   [2];
    bit         eerr  [2];
    bit         erdy  [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rel[d] = 0; erv[d] = 0; eerr[d] = 0; ereg[d] = 8'h00; eregk[d] = 1; erdy[d] = 0;
            end else begin
                erv[d] = 0; eerr[d] = 0;
                if (cs[d] && erdy[d]) begin
                    if (int'(addr[d]) >= dep(d)) begin
                        eerr[d] = 1;
                        if (!we[d]) begin erv[d] = 1; ereg[d] = 8'h00; eregk[d] = 1; end
                    end else if (we[d]) begin
                        mm[d][addr[d]] = din[d]; kn[d][addr[d]] = 1;
                    end else begin
                        erv[d] = 1; ereg[d] = mm[d][addr[d]]; eregk[d] = kn[d][addr[d]];
                    end
                end
                rel[d] = rel[d] + 1;
                if (c_SWEEP && rel[d] == dep(d))
                    for (int i = 0; i < dep(d); i++) begin mm[d][i] = 8'h00; kn[d][i] = 1; end
                erdy[d] = (rel[d] >= (c_SWEEP ? dep(d) : 1));
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            cmp($sformatf("ready[%0d]", d), 32'(rdy[d]), 32'(erdy[d]));
            cmp($sformatf("rd_valid[%0d]", d), 32'(rv[d]), 32'(erv[d]));
            cmp($sformatf("err[%0d]", d), 32'(er[d]), 32'(eerr[d]));
            if (!oe[d] || eregk[d])
                cmp($sformatf("data_out[%0d]", d), 32'(dout[d]), oe[d] ? 32'(ereg[d]) : 32'h0);
        end
    endtask

    // Advance one clock; outputs are compared on the falling edge before it.
    task automatic step();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input int d, input bit w, input logic [3:0] a, input logic [7:0] dt, input bit o);
        cs[d] = 1'b1; we[d] = w; addr[d] = a; din[d] = dt; oe[d] = o;
        step();
        cs[d] = 1'b0;
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((!rdy[0] || !rdy[1]) && n < 50) begin n++; step(); end
        cmp("ready_wait", 32'(rdy[0] & rdy[1]), 32'h1);
    endtask

    task automatic count_not_ready(input string nm);
        int n = 0;
        while (!rdy[0] && n < 40) begin n++; step(); end
        cmp(nm, n, c_SWEEP ? 16 : 1);
        #1;
    endtask

    int  ra;
    bit  rw;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs = '0; we = '0; oe = '0; addr = '0; din = '0;
        step();
        chk_en = 1;
        step(); step();
        cmp("reset_ready", 32'(rdy[0]), 32'h0);
        cmp("reset_dout", 32'(dout[0]), 32'h0);
        cmp("reset_rd_valid", 32'(rv[0]), 32'h0);

        rst = 1'b0;
        count_not_ready("ready_low_cycles");
        wait_ready();

`ifdef SPRAM_INIT_CLEAR_EN
        acc(0, 0, 4'd5, 8'h00, 1);
        cmp("sweep_read5_data", 32'(dout[0]), 32'h0);
        cmp("sweep_read5_valid", 32'(rv[0]), 32'h1);
`endif

        acc(0, 1, 4'd3, 8'h5A, 1);
        acc(0, 0, 4'd3, 8'h00, 1);
        cmp("wr_rd_data", 32'(dout[0]), 32'h5A);
        cmp("wr_rd_valid", 32'(rv[0]), 32'h1);
        step(); #1;
        cmp("rd_valid_single", 32'(rv[0]), 32'h0);
        cmp("dout_hold", 32'(dout[0]), 32'h5A);

        acc(0, 0, 4'd3, 8'h00, 0);
        cmp("oe0_data", 32'(dout[0]), 32'h0);
        cmp("oe0_valid", 32'(rv[0]), 32'h1);
        oe[0] = 1'b1; #1;
        cmp("oe1_data", 32'(dout[0]), 32'h5A);
        step(); #1;
        cmp("oe1_novalid", 32'(rv[0]), 32'h0);

        acc(1, 1, 4'd11, 8'h3C, 1);
        acc(1, 1, 4'd1, 8'h11, 1);
        acc(1, 1, 4'd13, 8'h77, 1);
        cmp("oor_wr_err", 32'(er[1]), 32'h1);
        cmp("oor_wr_novalid", 32'(rv[1]), 32'h0);
        acc(1, 0, 4'd13, 8'h00, 1);
        cmp("oor_rd_data", 32'(dout[1]), 32'h0);
        cmp("oor_rd_err", 32'(er[1]), 32'h1);
        cmp("oor_rd_valid", 32'(rv[1]), 32'h1);
        acc(1, 0, 4'd11, 8'h00, 1);
        cmp("oor_keep11", 32'(dout[1]), 32'h3C);
        cmp("oor_err_clear", 32'(er[1]), 32'h0);
        acc(1, 0, 4'd1, 8'h00, 1);
        cmp("oor_keep1", 32'(dout[1]), 32'h11);

        acc(0, 0, 4'd3, 8'h00, 1);
        rst = 1'b1;
        step(); #1;
        cmp("rst_after_rd_valid", 32'(rv[0]), 32'h0);
        cmp("rst_after_rd_dout", 32'(dout[0]), 32'h0);
        rst = 1'b0;
        wait_ready();

        acc(0, 1, 4'd7, 8'h99, 1);
        rst = 1'b1; step();
        rst = 1'b0;
        repeat (7) step();
        rst = 1'b1; step();
        rst = 1'b0;
        count_not_ready("midsweep_ready_low");
        wait_ready();
        acc(0, 0, 4'd7, 8'h00, 1);
        cmp("midsweep_read7", 32'(dout[0]), c_SWEEP ? 32'h0 : 32'h99);

        for (int i = 0; i < 16; i++) acc(0, 1, 4'(i), 8'(i + 1), 1);
        for (int i = 0; i < 16; i++) begin
            cs[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'(i); oe[0] = 1'b1;
            step(); #1;
            cmp($sformatf("stream_data%0d", i), 32'(dout[0]), 32'(i + 1));
            cmp($sformatf("stream_valid%0d", i), 32'(rv[0]), 32'h1);
            cmp($sformatf("stream_err%0d", i), 32'(er[0]), 32'h0);
        end
        cs[0] = 1'b0;
        step();

        for (int c = 0; c < 400; c++) begin
            rst = (c >= 200 && c < 202);
            for (int d = 0; d < 2; d++) begin
                ra = int'($urandom_range(0, 15));
                rw = 1'($urandom_range(0, 1));
                if (!rw && ra < dep(d) && !kn[d][ra]) rw = 1'b1;
                cs[d]   = ($urandom_range(0, 3) != 0);
                we[d]   = rw;
                addr[d] = 4'(ra);
                din[d]  = 8'($urandom);
                oe[d]   = 1'($urandom_range(0, 1));
            end
            step();
        end
        rst = 1'b0; cs = '0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
